// File: rtl/ulaplus_pkg.sv
// Shared ULAplus definitions: I/O port addresses, register groups and the
// palette controller state encoding.
package ulaplus_pkg;

  localparam logic [15:0] ULAPLUS_RS_PORT = 16'hBF3B;
  localparam logic [15:0] ULAPLUS_DP_PORT = 16'hFF3B;

  localparam logic [1:0] GRP_PALETTE = 2'b00;
  localparam logic [1:0] GRP_MODE    = 2'b01;

  localparam logic [5:0] PAL_LAST = 6'd63;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2
  } pal_state_t;

endpackage

// File: rtl/io_write_edge.sv
// Z80 I/O write strobe edge detector. Emits one pulse per I/O cycle however
// long the strobe is held, and captures the data byte of qualifying cycles.
module io_write_edge #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         strobe,
  input  logic         cap_en,
  input  logic [W-1:0] data,
  output logic         pulse,
  output logic [W-1:0] cap_data
);

  logic strobe_q;

  assign pulse = strobe & ~strobe_q;

  // Registered copy of the strobe for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) strobe_q <= 1'b0;
    else     strobe_q <= strobe;
  end

  // Latch the bus byte on the event; only enabled ports overwrite it.
  always_ff @(posedge clk) begin
    if (rst)                 cap_data <= '0;
    else if (pulse & cap_en) cap_data <= data;
  end

endmodule

// File: rtl/ulaplus_palette_port.sv
// ULAplus CPU-side port controller: decodes the register-select and data
// ports, owns the palette LUT write port and serves CPU read-back.
//
// state    | meaning
// ST_CLEAR | zeroing palette entries 0..63, one per cycle
// ST_IDLE  | waiting for CPU writes; replays a deferred data write
// ST_WRITE | single-cycle palette write of the captured byte
module ulaplus_palette_port
  import ulaplus_pkg::*;
#(
  parameter bit AUTOINC = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        oe,
  output logic        lut_load,
  output logic [5:0]  lut_addr,
  output logic [7:0]  lut_din,
  input  logic [7:0]  lut_dout,
  output logic        ulaplus_en,
  output logic        busy
);

  pal_state_t state, state_nx;

  logic       sel_rs, sel_dp, wr_act;
  logic       ev, ev_rs, ev_dp;
  logic [7:0] cap_data;
  logic [5:0] cnt, idx;
  logic [1:0] group;
  logic       pend;
  logic       idle, replay, do_now, defer, pal_wr;

  assign sel_rs = ~iorq_n & (a == ULAPLUS_RS_PORT);
  assign sel_dp = ~iorq_n & (a == ULAPLUS_DP_PORT);
  assign wr_act = (sel_rs | sel_dp) & ~wr_n;
  assign oe     = (sel_rs | sel_dp) & ~rd_n;

  // Only data-port bytes are captured, so cap_data doubles as the pending
  // write store: a later register-select write cannot clobber it.
  io_write_edge #(.W(8)) u_edge (
    .clk      (clk),
    .rst      (rst),
    .strobe   (wr_act),
    .cap_en   (sel_dp),
    .data     (din),
    .pulse    (ev),
    .cap_data (cap_data)
  );

  assign ev_rs  = ev & sel_rs;
  assign ev_dp  = ev & sel_dp;
  assign idle   = (state == ST_IDLE);
  assign replay = idle & pend;
  assign do_now = idle & ev_dp;
  assign defer  = ev_dp & ~idle;
  assign pal_wr = lut_load & (state != ST_CLEAR);
  assign busy   = (state == ST_CLEAR);

  // State register; reset always restarts the palette clear.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_CLEAR;
    else     state <= state_nx;
  end

  // Next state and LUT port drive. A replayed palette write completes in the
  // IDLE cycle itself so it lands right after the clear finishes.
  always_comb begin
    state_nx = state;
    lut_load = 1'b0;
    lut_addr = idx;
    lut_din  = cap_data;
    case (state)
      ST_CLEAR: begin
        lut_load = 1'b1;
        lut_addr = cnt;
        lut_din  = 8'h00;
        if (cnt == PAL_LAST) state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        if (replay && group == GRP_PALETTE) lut_load = 1'b1;
        if (do_now && group == GRP_PALETTE) state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        lut_load = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_CLEAR;
    endcase
    if (rst) lut_load = 1'b0;
  end

  // Clear address counter; wraps back to 0 as the clear completes.
  always_ff @(posedge clk) begin
    if (rst)                  cnt <= 6'd0;
    else if (state == ST_CLEAR) cnt <= cnt + 6'd1;
  end

  // Register-select writes are applied immediately; auto-increment follows
  // every palette data write.
  always_ff @(posedge clk) begin
    if (rst) begin
      group <= GRP_PALETTE;
      idx   <= 6'd0;
    end else if (ev_rs) begin
      group <= din[7:6];
      idx   <= din[5:0];
    end else if (AUTOINC && pal_wr) begin
      idx   <= idx + 6'd1;
    end
  end

  // Mode register; a fresh write in the replay cycle wins over the replay.
  always_ff @(posedge clk) begin
    if (rst) begin
      ulaplus_en <= 1'b0;
    end else begin
      if (replay && group == GRP_MODE) ulaplus_en <= cap_data[0];
      if (do_now && group == GRP_MODE) ulaplus_en <= din[0];
    end
  end

  // One-deep deferral of data writes arriving while the LUT port is busy.
  always_ff @(posedge clk) begin
    if (rst)         pend <= 1'b0;
    else if (defer)  pend <= 1'b1;
    else if (replay) pend <= 1'b0;
  end

  // CPU read mux; floats high when the block is not addressed.
  always_comb begin
    dout = 8'hFF;
    if (oe) begin
      if (sel_rs) begin
        dout = {group, idx};
      end else begin
        case (group)
          GRP_PALETTE: dout = lut_dout;
          GRP_MODE:    dout = {7'b0, ulaplus_en};
          default:     dout = 8'hFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ulaplus_palette_port.sv
// Scoreboard bench for ulaplus_palette_port: CPU stimulus pushes expected LUT
// writes and read data; a negedge monitor pops and compares.
module tb_ulaplus_palette_port;

  localparam bit          AUTOINC = 1'b1;
  localparam logic [15:0] RS      = 16'hBF3B;
  localparam logic [15:0] DP      = 16'hFF3B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = 16'h0000;
  logic        iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic        oe, lut_load, ulaplus_en, busy;
  logic [5:0]  lut_addr;
  logic [7:0]  lut_din, lut_dout;

  ulaplus_palette_port #(.AUTOINC(AUTOINC)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .iorq_n     (iorq_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .din        (din),
    .dout       (dout),
    .oe         (oe),
    .lut_load   (lut_load),
    .lut_addr   (lut_addr),
    .lut_din    (lut_din),
    .lut_dout   (lut_dout),
    .ulaplus_en (ulaplus_en),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int rel0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Palette LUT: synchronous write, combinational read.
  logic [7:0] lut_mem [64];
  always @(posedge clk) if (lut_load) lut_mem[lut_addr] <= lut_din;
  assign lut_dout = lut_mem[lut_addr];

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_exp_t;

  wr_exp_t    wr_q[$];
  logic [7:0] rd_q[$];

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state.
  logic [7:0] m_pal [64];
  logic [1:0] m_grp;
  logic [5:0] m_idx;
  logic       m_en;
  logic       m_pend_v;
  logic [7:0] m_pend_d;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Monitor: compare every LUT write and every read against the scoreboard.
  wr_exp_t    e;
  logic [7:0] r;
  logic       oe_prev = 1'b0;
  always @(negedge clk) begin
    if (lut_load) begin
      if (wr_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_lut_load: got addr %0d data 0x%0h, expected no write", lut_addr, lut_din);
      end else begin
        e = wr_q.pop_front();
        chk("lut_addr", lut_addr, e.addr);
        chk("lut_din", lut_din, e.data);
        if (e.cyc >= 0) chk("lut_load_cycle", cyc - rel0, e.cyc);
      end
    end
    if (oe && !oe_prev) begin
      if (rd_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_read: got dout 0x%0h, expected no read", dout);
      end else begin
        r = rd_q.pop_front();
        chk("read_dout", dout, r);
      end
    end
    oe_prev = oe;
  end

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_pal[i] = 8'h00;
    m_grp = 2'b00; m_idx = 6'd0; m_en = 1'b0;
    m_pend_v = 1'b0; m_pend_d = 8'h00;
  endfunction

  function automatic void model_dp(input logic [7:0] d, input bit push);
    case (m_grp)
      2'b00: begin
        if (push) wr_q.push_back('{addr: m_idx, data: d, cyc: -1});
        m_pal[m_idx] = d;
        if (AUTOINC) m_idx = m_idx + 6'd1;
      end
      2'b01: m_en = d[0];
      default: ;
    endcase
  endfunction

  // A data write during the clear waits and is written at cycle 64; a second
  // one replaces it.
  function automatic void model_out(input logic [15:0] addr, input logic [7:0] d, input bit clearing);
    if (addr == RS) begin
      m_grp = d[7:6];
      m_idx = d[5:0];
    end else if (addr == DP) begin
      if (clearing) begin
        if (m_pend_v && m_grp == 2'b00) void'(wr_q.pop_back());
        m_pend_v = 1'b1;
        m_pend_d = d;
        if (m_grp == 2'b00) wr_q.push_back('{addr: m_idx, data: d, cyc: 64});
      end else begin
        model_dp(d, 1'b1);
      end
    end
  endfunction

  function automatic void model_apply_pend();
    if (m_pend_v) model_dp(m_pend_d, 1'b0);
    m_pend_v = 1'b0;
  endfunction

  function automatic logic [7:0] model_in(input logic [15:0] addr);
    if (addr == RS) return {m_grp, m_idx};
    case (m_grp)
      2'b00:   return m_pal[m_idx];
      2'b01:   return {7'b0, m_en};
      default: return 8'hFF;
    endcase
  endfunction

  task automatic io_write(input logic [15:0] addr, input logic [7:0] d, input int len, input bit iorq);
    @(posedge clk); #1;
    a = addr; din = d; iorq_n = ~iorq; wr_n = 1'b0;
    repeat (len - 1) @(posedge clk);
    @(posedge clk); #1;
    iorq_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic cpu_out(input logic [15:0] addr, input logic [7:0] d, input int len, input bit clearing);
    model_out(addr, d, clearing);
    io_write(addr, d, len, 1'b1);
  endtask

  task automatic cpu_in(input logic [15:0] addr);
    rd_q.push_back(model_in(addr));
    @(posedge clk); #1;
    a = addr; iorq_n = 1'b0; rd_n = 1'b0;
    @(posedge clk); #1;
    iorq_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    wr_q.delete(); rd_q.delete();
    model_reset();
    @(negedge clk);
    chk("lut_load_in_reset", lut_load, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rel0 = cyc;
    for (int i = 0; i < 64; i++) wr_q.push_back('{addr: 6'(i), data: 8'h00, cyc: i});
  endtask

  task automatic wait_clear();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("busy_fall_cycle", cyc - rel0, 64);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g;

    // Clear after reset.
    do_reset();
    wait_clear();
    chk("ulaplus_en_reset", ulaplus_en, 0);

    // Palette write with a long strobe, then read-back.
    cpu_out(RS, 8'h05, 1, 1'b0);
    cpu_out(DP, 8'hA7, 6, 1'b0);
    cpu_in(DP);
    cpu_in(RS);
    cpu_out(RS, 8'h05, 1, 1'b0);
    cpu_in(DP);

    // Mode register and unused groups.
    cpu_out(RS, 8'h40, 1, 1'b0);
    cpu_out(DP, 8'h01, 3, 1'b0);
    chk("ulaplus_en_set", ulaplus_en, 1);
    cpu_in(DP);
    cpu_out(RS, 8'h80, 1, 1'b0);
    cpu_in(DP);
    cpu_out(RS, 8'hC0, 1, 1'b0);
    cpu_out(DP, 8'h55, 2, 1'b0);
    cpu_in(DP);

    // Auto-increment wrap 62 -> 63 -> 0.
    cpu_out(RS, 8'h3E, 1, 1'b0);
    cpu_out(DP, 8'h11, 1, 1'b0);
    cpu_out(DP, 8'h22, 2, 1'b0);
    cpu_out(DP, 8'h33, 1, 1'b0);
    cpu_in(RS);
    cpu_out(RS, 8'h3E, 1, 1'b0);
    cpu_in(DP);
    cpu_out(RS, 8'h3F, 1, 1'b0);
    cpu_in(DP);
    cpu_out(RS, 8'h00, 1, 1'b0);
    cpu_in(DP);

    // Undecoded accesses.
    io_write(16'hBF3A, 8'h99, 2, 1'b1);
    io_write(DP, 8'h99, 2, 1'b0);
    @(posedge clk); #1;
    a = DP; iorq_n = 1'b1; rd_n = 1'b0;
    @(negedge clk);
    chk("oe_no_iorq", oe, 0);
    chk("dout_idle", dout, 8'hFF);
    @(posedge clk); #1;
    a = 16'hBF3A; iorq_n = 1'b0;
    @(negedge clk);
    chk("oe_bad_addr", oe, 0);
    @(posedge clk); #1;
    iorq_n = 1'b1; rd_n = 1'b1;

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 4))
        0: begin
          g = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
          cpu_out(RS, {g, 6'($urandom_range(0, 63))}, $urandom_range(1, 3), 1'b0);
        end
        1, 2: cpu_out(DP, 8'($urandom), $urandom_range(1, 3), 1'b0);
        3: cpu_in(RS);
        default: cpu_in(DP);
      endcase
      if (k % 20 == 0) chk("ulaplus_en_rand", ulaplus_en, m_en);
    end

    // Data writes during the clear: the second replaces the first.
    do_reset();
    repeat (9) @(posedge clk);
    cpu_out(DP, 8'h5A, 2, 1'b1);
    repeat (7) @(posedge clk);
    cpu_out(DP, 8'hC3, 1, 1'b1);
    wait_clear();
    model_apply_pend();
    cpu_in(RS);
    cpu_out(RS, 8'h00, 1, 1'b0);
    cpu_in(DP);

    // Reset mid-clear drops the pending write and restarts from entry 0.
    do_reset();
    repeat (9) @(posedge clk);
    cpu_out(DP, 8'h77, 1, 1'b1);
    repeat (18) @(posedge clk);
    do_reset();
    wait_clear();
    repeat (10) @(posedge clk);
    cpu_in(RS);
    cpu_in(DP);

    repeat (4) @(posedge clk);
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("rd_queue_drained", rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ulaplus_palette_port.md
# ulaplus_palette_port

CPU-side ULAplus I/O port controller: the writer/reader that owns the 64-entry palette LUT.
- Decodes the ULAplus register-select port (0xBF3B) and data port (0xFF3B) from Z80 I/O cycles.
- Turns each CPU I/O write into exactly one single-cycle LUT write, or a mode-register update.
- Serves CPU reads of the selected palette entry or the mode register.
- After every reset, clears the whole palette.
- Sits between the Z80 bus glue and the palette LUT's write/third read port; the ULA reads the other LUT ports.

## Interface
- AUTOINC, 0, when 1 the selected index increments (63 wraps to 0) after each palette data write
- clk  in  1  system clock
- rst  in  1  reset; synchronous and active-high
- a  in  16  Z80 address bus
- iorq_n  in  1  Z80 I/O request, active low
- rd_n  in  1  Z80 read strobe, active low
- wr_n  in  1  Z80 write strobe, active low
- din  in  8  Z80 data bus, CPU to block
- dout  out  8  read data to CPU bus
- oe  out  1  dout valid; drives the bus mux
- lut_load  out  1  one-cycle palette write enable
- lut_addr  out  6  palette address, shared by write and read-back
- lut_din  out  8  palette write data
- lut_dout  in  8  palette entry at lut_addr; combinational LUT read
- ulaplus_en  out  1  mode register bit 0
- busy  out  1  palette clear in progress

## Operation
- Decode
  - sel_rs = ~iorq_n & (a==16'hBF3B)
  - sel_dp = ~iorq_n & (a==16'hFF3B)
  - Full 16-bit decode.
- Write strobe
  - wr_act = (sel_rs|sel_dp) & ~wr_n.
  - A write event is the rising edge of wr_act against its registered copy.
  - On a write event, din and the target port are captured.
  - One event per I/O cycle, however long the strobe is held.
- Register-select write
  - group <= din[7:6]
  - idx <= din[5:0]
  - Takes effect the cycle after the event.
- Data write, group 00: palette write of captured data to entry idx via lut_load.
- Data write, group 01: ulaplus_en <= din[0].
- Data write, groups 10/11: ignored; no lut_load.
- Reads, with oe = (sel_rs|sel_dp) & ~rd_n, combinational:
  - Register-select port: dout = {group, idx}.
  - Data port, group 00: dout = lut_dout.
  - Data port, group 01: dout = {7'b0, ulaplus_en}.
  - Data port, groups 10/11: dout = 8'hFF.
  - When oe=0: dout = 8'hFF.
- lut_addr
  - CLEAR: clear counter.
  - Otherwise: idx.
- FSM
  - CLEAR: lut_load=1, lut_din=0, lut_addr=cnt, cnt++ each cycle. After entry 63 → IDLE.
  - IDLE: on a write event → WRITE.
  - WRITE: lut_load=1 for one cycle; if AUTOINC, idx++ at the end of the cycle → IDLE.
- Pending write
  - Holds one captured data-port write that arrives during CLEAR or WRITE.
  - Replayed on the first IDLE cycle. A second arrival while pending overwrites it.
  - Register-select writes are never deferred.
- Reset values
  - group=00, idx=0, ulaplus_en=0, lut_load=0 (in the reset cycle), pending=0.
  - State=CLEAR, cnt=0, busy=1.
  - Reset asserted during CLEAR or WRITE restarts the clear from entry 0; a pending write is discarded.

## Timing
- Reset released at cycle 0: lut_load=1 in cycles 0..63 (addr 0..63, data 0); busy falls at cycle 64.
- Write event detected at cycle t (IDLE): lut_load=1 at t+1 with lut_addr=idx, lut_din=captured byte; idx increment, if AUTOINC, visible at t+2.
- Mode write at t: ulaplus_en changes at t+1.
- Read: combinational, zero latency; a read at t+2 sees a palette write made at t+1.
- Minimum spacing between write events is 2 cycles, since wr_act must fall for at least one cycle.

## Structure
- Shared package ulaplus_pkg:
  - constants ULAPLUS_RS_PORT=16'hBF3B, ULAPLUS_DP_PORT=16'hFF3B
  - group codes GRP_PALETTE=2'b00, GRP_MODE=2'b01
  - FSM state encoding CLEAR/IDLE/WRITE
- One sub-module: io_write_edge (registered strobe, rising-edge pulse, data/port capture); reused by other ULA-side port handlers.

## Test plan
- Reset then release → 64 consecutive lut_load cycles, addr 0..63, lut_din=0; busy=1 for exactly 64 cycles, then 0.
- OUT 0xBF3B,0x05 then OUT 0xFF3B,0xA7 (strobe held 6 cycles) → exactly one lut_load, addr 5, data 0xA7; IN 0xFF3B → 0xA7; IN 0xBF3B → 0x05.
- OUT 0xBF3B,0x40; OUT 0xFF3B,0x01 → ulaplus_en=1, no lut_load; IN 0xFF3B → 0x01; select 0x80, IN 0xFF3B → 0xFF.
- AUTOINC=1: select idx 62, write 0x11,0x22,0x33 → entries 62,63,0 written; IN 0xBF3B → 0x01.
- Data write issued at cycle 10 after reset (during CLEAR) → held pending, written at cycle 64 after clear completes; reset asserted mid-clear → clear restarts at entry 0, pending dropped.
- Address 0xBF3A / 0xFF3B with iorq_n=1 → no decode, oe=0, no lut_load.
